// File: rtl/seg_scan_if.sv
// Pin and control bundle between the display datapath (master) and seg_scan_driver (slave).
// Handshake: load is a one-cycle strobe with no ready; pending reads 1 from the edge after a load until the frame swap.
interface seg_scan_if #(
    parameter int NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] inDigit;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    load;
    logic [3:0]              brightness;
    logic [6:0]              Cnode;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   AN;
    logic                    frame_tick;
    logic                    pending;

    modport master (
        output inDigit, dp_in, digit_en, load, brightness,
        input  Cnode, dp, AN, frame_tick, pending
    );

    modport slave (
        input  inDigit, dp_in, digit_en, load, brightness,
        output Cnode, dp, AN, frame_tick, pending
    );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment scanner with double-buffered load and PWM dimming.
// Optional macro SEG_LEADING_ZERO_BLANK_EN darkens leading zero digits at load time.
module seg_scan_driver #(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int IDX_W       = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    seg_scan_if.slave  bus
);
    localparam int CNT_W = $clog2(REFRESH_DIV);

    logic [CNT_W-1:0]        slot_cnt;
    logic [IDX_W-1:0]        idx;
    logic [3:0]              pwm_cnt;
    logic                    pending_r;
    logic [4*NUM_DIGITS-1:0] pend_digit, act_digit;
    logic [NUM_DIGITS-1:0]   pend_dp, act_dp;
    logic [NUM_DIGITS-1:0]   pend_en, act_en;
    logic [NUM_DIGITS-1:0]   en_cap;

    logic                    slot_end, frame_wrap;
    logic                    lit;
    logic [3:0]              cur_nib;
    logic                    cur_dp, cur_en;
    logic [NUM_DIGITS-1:0]   an_next;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        case (nib)
            4'h0: decode = 7'b1000000;
            4'h1: decode = 7'b1111001;
            4'h2: decode = 7'b0100100;
            4'h3: decode = 7'b0110000;
            4'h4: decode = 7'b0011001;
            4'h5: decode = 7'b0010010;
            4'h6: decode = 7'b0000010;
            4'h7: decode = 7'b1111000;
            4'h8: decode = 7'b0000000;
            4'h9: decode = 7'b0010000;
            4'hA: decode = 7'b0001000;
            4'hB: decode = 7'b0000011;
            4'hC: decode = 7'b1000110;
            4'hD: decode = 7'b0100001;
            4'hE: decode = 7'b0000110;
            default: decode = 7'b0001110;
        endcase
    endfunction

    assign slot_end   = (slot_cnt == CNT_W'(REFRESH_DIV - 1));
    assign frame_wrap = slot_end && (idx == IDX_W'(NUM_DIGITS - 1));

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic above_nz;
    logic nib_nz;

    // Walk from the most significant digit down so above_nz means "some higher digit is nonzero".
    always_comb begin
        en_cap   = bus.digit_en;
        above_nz = 1'b0;
        nib_nz   = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            nib_nz    = (bus.inDigit[4*k +: 4] != 4'h0);
            en_cap[k] = bus.digit_en[k] && (nib_nz || (k == 0) || above_nz);
            above_nz  = above_nz | nib_nz;
        end
    end
`else
    assign en_cap = bus.digit_en;
`endif

    // Select the active digit's fields with an explicit compare so idx never indexes out of range.
    always_comb begin
        cur_nib = 4'h0;
        cur_dp  = 1'b0;
        cur_en  = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_nib = act_digit[4*i +: 4];
                cur_dp  = act_dp[i];
                cur_en  = act_en[i];
            end
        end
    end

    assign lit = (pwm_cnt <= bus.brightness) && cur_en;

    always_comb begin
        an_next = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            an_next[i] = !(lit && (idx == IDX_W'(i)));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_cnt       <= '0;
            idx            <= '0;
            pwm_cnt        <= '0;
            pending_r      <= 1'b0;
            pend_digit     <= '0;
            pend_dp        <= '0;
            pend_en        <= '0;
            act_digit      <= '0;
            act_dp         <= '0;
            act_en         <= '0;
            bus.frame_tick <= 1'b0;
            bus.AN         <= '1;
            bus.Cnode      <= 7'h7F;
            bus.dp         <= 1'b1;
        end else begin
            slot_cnt <= slot_end ? '0 : slot_cnt + CNT_W'(1);
            if (slot_end) begin
                idx <= frame_wrap ? '0 : idx + IDX_W'(1);
            end
            pwm_cnt        <= pwm_cnt + 4'd1;
            bus.frame_tick <= frame_wrap;

            // A load on the swap edge lands in pending after the old pending word moved to active.
            if (frame_wrap && pending_r) begin
                act_digit <= pend_digit;
                act_dp    <= pend_dp;
                act_en    <= pend_en;
                pending_r <= 1'b0;
            end
            if (bus.load) begin
                pend_digit <= bus.inDigit;
                pend_dp    <= bus.dp_in;
                pend_en    <= en_cap;
                pending_r  <= 1'b1;
            end

            bus.AN    <= an_next;
            bus.Cnode <= lit ? decode(cur_nib) : 7'h7F;
            bus.dp    <= lit ? ~cur_dp : 1'b1;
        end
    end

    assign bus.pending = pending_r;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: 8 digits, 4-cycle slots, so one frame is 32 cycles.
module tb_seg_scan_driver;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [15:0] exp_q[$];
    logic [7:0]  prev_an;
    logic [6:0]  seg_tab[16];

    seg_scan_if #(.NUM_DIGITS(8)) bus();

    seg_scan_driver #(
        .NUM_DIGITS (8),
        .REFRESH_DIV(4),
        .IDX_W      (3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // driver tasks
    task automatic do_load(input logic [31:0] word, input logic [7:0] dpv, input logic [7:0] en);
        @(negedge clk);
        bus.inDigit  = word;
        bus.dp_in    = dpv;
        bus.digit_en = en;
        bus.load     = 1'b1;
        @(negedge clk);
        bus.load     = 1'b0;
    endtask

    task automatic wait_tick(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.frame_tick && n < 200);
        check(name, {31'd0, bus.frame_tick}, 32'd1);
    endtask

    task automatic count_lit(input int cycles, output int lit);
        lit = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.AN != 8'hFF) lit++;
        end
    endtask

    task automatic count_high_lit(input int cycles, output int lit);
        lit = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.AN[7:3] != 5'h1F) lit++;
        end
    endtask

    // expected {AN, Cnode, dp} for each slot of the next frame whose digit is enabled
    task automatic push_frame(input logic [31:0] word, input logic [7:0] dpv, input logic [7:0] en);
        logic [7:0] an_e;
        logic [3:0] nib;
        for (int i = 0; i < 8; i++) begin
            if (en[i]) begin
                an_e = ~(8'h01 << i);
                nib  = word[4*i +: 4];
                exp_q.push_back({an_e, seg_tab[nib], ~dpv[i]});
            end
        end
    endtask

    // scoreboard monitor: a new lit AN value marks a new slot
    always @(negedge clk) begin
        logic [15:0] e;
        if (rst_n && bus.AN != 8'hFF && bus.AN != prev_an && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({bus.AN, bus.Cnode, bus.dp} !== e) begin
                errors++;
                $display("FAIL slot AN=%h Cnode=%b dp=%b expected AN=%h Cnode=%b dp=%b",
                         bus.AN, bus.Cnode, bus.dp, e[15:8], e[7:1], e[0]);
            end
        end
        prev_an = bus.AN;
    end

    initial begin
        int n;
        checks = 0;
        errors = 0;
        prev_an = 8'hFF;
        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        rst_n          = 1'b0;
        bus.inDigit    = '0;
        bus.dp_in      = '0;
        bus.digit_en   = '0;
        bus.load       = 1'b0;
        bus.brightness = 4'd15;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_an", {24'd0, bus.AN}, 32'hFF);
        check("rst_cnode", {25'd0, bus.Cnode}, 32'h7F);
        check("rst_dp", {31'd0, bus.dp}, 32'd1);
        check("rst_tick", {31'd0, bus.frame_tick}, 32'd0);
        check("rst_pending", {31'd0, bus.pending}, 32'd0);
        rst_n = 1'b1;

        // empty active buffer keeps every digit dark
        count_lit(40, n);
        check("empty_dark", n, 0);

        // single nonzero digit
        do_load(32'h0000_0004, 8'h00, 8'hFF);
        check("pend_set", {31'd0, bus.pending}, 32'd1);
        wait_tick("tick_a");
        check("pend_clr", {31'd0, bus.pending}, 32'd0);
        push_frame(32'h0000_0004, 8'h00, 8'hFF);
        wait_tick("tick_b");

        // full hex word with dp on digit 0, two frames
        repeat (3) @(negedge clk);
        do_load(32'h89AB_CDEF, 8'h01, 8'hFF);
        wait_tick("tick_c");
        push_frame(32'h89AB_CDEF, 8'h01, 8'hFF);
        wait_tick("tick_d");
        push_frame(32'h89AB_CDEF, 8'h01, 8'hFF);
        wait_tick("tick_e");

        // PWM duty
        bus.brightness = 4'd3;
        repeat (4) @(negedge clk);
        count_lit(16, n);
        check("duty_3", n, 4);
        bus.brightness = 4'd0;
        repeat (4) @(negedge clk);
        count_lit(16, n);
        check("duty_0", n, 1);
        bus.brightness = 4'd15;

        // load coinciding with the frame swap edge
        wait_tick("tick_f");
        repeat (30) @(negedge clk);
        bus.inDigit  = 32'h7654_3210;
        bus.dp_in    = 8'h00;
        bus.digit_en = 8'hFF;
        bus.load     = 1'b1;
        @(negedge clk);
        bus.inDigit  = 32'hFEDC_BA98;
        bus.dp_in    = 8'h80;
        @(negedge clk);
        bus.load     = 1'b0;
        check("coll_tick", {31'd0, bus.frame_tick}, 32'd1);
        check("coll_pend", {31'd0, bus.pending}, 32'd1);
        push_frame(32'h7654_3210, 8'h00, 8'hFF);
        wait_tick("tick_g");
        check("coll_pend_clr", {31'd0, bus.pending}, 32'd0);
        push_frame(32'hFEDC_BA98, 8'h80, 8'hFF);
        wait_tick("tick_h");

        // leading zeros
        repeat (3) @(negedge clk);
        do_load(32'h0000_0400, 8'h00, 8'hFF);
        wait_tick("tick_i");
`ifdef SEG_LEADING_ZERO_BLANK_EN
        push_frame(32'h0000_0400, 8'h00, 8'h07);
        count_high_lit(32, n);
        check("lz_dark", n, 0);
`else
        push_frame(32'h0000_0400, 8'h00, 8'hFF);
        count_high_lit(32, n);
        check("lz_lit", n, 20);
`endif
        wait_tick("tick_j");

        // reset in the middle of a load discards pending and active words
        repeat (3) @(negedge clk);
        do_load(32'h1111_1111, 8'hFF, 8'hFF);
        check("pend_before_rst", {31'd0, bus.pending}, 32'd1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("pend_after_rst", {31'd0, bus.pending}, 32'd0);
        check("an_after_rst", {24'd0, bus.AN}, 32'hFF);
        rst_n = 1'b1;
        count_lit(40, n);
        check("dark_after_rst", n, 0);

        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
